// File: rtl/clint_bus_arb.sv
// Two-master arbiter in front of the CLINT register port: grants one master at a time,
// issues a one-cycle write or read strobe, waits for the read response and returns ack/data.
module clint_bus_arb #(
   parameter int TIMEOUT = 8,
   parameter bit RR_EN   = 1'b1
) (
   input  logic        clk,
   input  logic        resetb,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_gnt,
   output logic        m0_ack,
   output logic        m0_err,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_gnt,
   output logic        m1_ack,
   output logic        m1_err,
   output logic [31:0] m1_rdata,
   output logic        s_wready,
   output logic [31:0] s_waddr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   output logic        s_rready,
   output logic [31:0] s_raddr,
   input  logic        s_rresp,
   input  logic [31:0] s_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

   state_t      r_state;
   logic        r_ptr;
   logic        r_id;
   logic        r_we;
   logic [7:0]  r_cnt;
   logic        r_wready;
   logic        r_rready;
   logic [31:0] r_waddr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic [31:0] r_raddr;
   logic [1:0]  r_ack;
   logic [1:0]  r_err;
   logic [31:0] r_rdata0;
   logic [31:0] r_rdata1;

   logic        w_sel;
   logic        w_grant;
   logic        w_selWe;
   logic [31:0] w_selAddr;
   logic [31:0] w_selWdata;
   logic [3:0]  w_selWstrb;
   logic [7:0]  w_cntNext;

   // m1 wins when alone, or when both ask and the round-robin pointer favours it.
   assign w_sel      = m1_req & (~m0_req | (RR_EN & r_ptr));
   assign w_grant    = (r_state == IDLE) & (m0_req | m1_req) & ~resetb;
   assign w_selWe    = w_sel ? m1_we    : m0_we;
   assign w_selAddr  = w_sel ? m1_addr  : m0_addr;
   assign w_selWdata = w_sel ? m1_wdata : m0_wdata;
   assign w_selWstrb = w_sel ? m1_wstrb : m0_wstrb;
   assign w_cntNext  = r_cnt + 8'd1;

   assign m0_gnt   = w_grant & ~w_sel;
   assign m1_gnt   = w_grant & w_sel;
   assign m0_ack   = r_ack[0];
   assign m1_ack   = r_ack[1];
   assign m0_err   = r_err[0];
   assign m1_err   = r_err[1];
   assign m0_rdata = r_rdata0;
   assign m1_rdata = r_rdata1;
   assign s_wready = r_wready;
   assign s_waddr  = r_waddr;
   assign s_wdata  = r_wdata;
   assign s_wstrb  = r_wstrb;
   assign s_rready = r_rready;
   assign s_raddr  = r_raddr;

   // Strobes, ack and err are one-cycle pulses: cleared every cycle unless re-asserted.
   always_ff @(posedge clk or posedge resetb) begin
      if (resetb) begin
         r_state  <= IDLE;
         r_ptr    <= 1'b0;
         r_id     <= 1'b0;
         r_we     <= 1'b0;
         r_cnt    <= 8'd0;
         r_wready <= 1'b0;
         r_rready <= 1'b0;
         r_waddr  <= 32'd0;
         r_wdata  <= 32'd0;
         r_wstrb  <= 4'd0;
         r_raddr  <= 32'd0;
         r_ack    <= 2'b00;
         r_err    <= 2'b00;
         r_rdata0 <= 32'd0;
         r_rdata1 <= 32'd0;
      end else begin
         r_wready <= 1'b0;
         r_rready <= 1'b0;
         r_ack    <= 2'b00;
         r_err    <= 2'b00;
         case (r_state)
            IDLE: begin
               if (w_grant) begin
                  r_id     <= w_sel;
                  r_we     <= w_selWe;
                  r_wready <= w_selWe;
                  r_rready <= ~w_selWe;
                  if (w_selWe) begin
                     r_waddr <= w_selAddr;
                     r_wdata <= w_selWdata;
                     r_wstrb <= w_selWstrb;
                  end else begin
                     r_raddr <= w_selAddr;
                  end
                  if (RR_EN) r_ptr <= ~w_sel;
                  r_state <= ISSUE;
               end
            end
            ISSUE: begin
               r_cnt <= 8'd0;
               if (r_we) begin
                  r_ack[r_id] <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (s_rresp) begin
                  r_ack[r_id] <= 1'b1;
                  if (r_id) r_rdata1 <= s_rdata;
                  else      r_rdata0 <= s_rdata;
                  r_state <= DONE;
               end else if (w_cntNext == TO_LIM) begin
                  r_ack[r_id] <= 1'b1;
                  r_err[r_id] <= 1'b1;
                  if (r_id) r_rdata1 <= 32'd0;
                  else      r_rdata0 <= 32'd0;
                  r_state <= DONE;
               end else begin
                  r_cnt <= w_cntNext;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_clint_bus_arb.sv
// Self-checking bench for clint_bus_arb: a transaction-timeline model predicts every output
// each cycle, a small CLINT stub answers reads, and literal expectations pin key scenarios.
module tb_clint_bus_arb;

   localparam int          TIMEOUT       = 8;
   localparam logic [31:0] MSIP_BASE     = 32'h0200_0000;
   localparam logic [31:0] MTIMECMP_BASE = 32'h0200_4000;

   logic clk = 1'b0;
   logic resetb = 1'b1;

   logic        req[2];
   logic        mWe[2];
   logic [31:0] mAddr[2];
   logic [31:0] mData[2];
   logic [3:0]  mStrb[2];
   logic        s_rresp;
   logic [31:0] s_rdata;

   logic        m0_gnt, m0_ack, m0_err, m1_gnt, m1_ack, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic        s_wready, s_rready;
   logic [31:0] s_waddr, s_wdata, s_raddr;
   logic [3:0]  s_wstrb;

   logic        fp_m0_gnt, fp_m0_ack, fp_m0_err, fp_m1_gnt, fp_m1_ack, fp_m1_err;
   logic [31:0] fp_m0_rdata, fp_m1_rdata;
   logic        fp_s_wready, fp_s_rready;
   logic [31:0] fp_s_waddr, fp_s_wdata, fp_s_raddr;
   logic [3:0]  fp_s_wstrb;

   clint_bus_arb #(.TIMEOUT(TIMEOUT), .RR_EN(1'b1)) dut (
      .clk(clk), .resetb(resetb),
      .m0_req(req[0]), .m0_we(mWe[0]), .m0_addr(mAddr[0]), .m0_wdata(mData[0]), .m0_wstrb(mStrb[0]),
      .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(req[1]), .m1_we(mWe[1]), .m1_addr(mAddr[1]), .m1_wdata(mData[1]), .m1_wstrb(mStrb[1]),
      .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .s_wready(s_wready), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_rready(s_rready), .s_raddr(s_raddr), .s_rresp(s_rresp), .s_rdata(s_rdata)
   );

   clint_bus_arb #(.TIMEOUT(TIMEOUT), .RR_EN(1'b0)) dutFp (
      .clk(clk), .resetb(resetb),
      .m0_req(req[0]), .m0_we(mWe[0]), .m0_addr(mAddr[0]), .m0_wdata(mData[0]), .m0_wstrb(mStrb[0]),
      .m0_gnt(fp_m0_gnt), .m0_ack(fp_m0_ack), .m0_err(fp_m0_err), .m0_rdata(fp_m0_rdata),
      .m1_req(req[1]), .m1_we(mWe[1]), .m1_addr(mAddr[1]), .m1_wdata(mData[1]), .m1_wstrb(mStrb[1]),
      .m1_gnt(fp_m1_gnt), .m1_ack(fp_m1_ack), .m1_err(fp_m1_err), .m1_rdata(fp_m1_rdata),
      .s_wready(fp_s_wready), .s_waddr(fp_s_waddr), .s_wdata(fp_s_wdata), .s_wstrb(fp_s_wstrb),
      .s_rready(fp_s_rready), .s_raddr(fp_s_raddr), .s_rresp(s_rresp), .s_rdata(s_rdata)
   );

   always #5 clk = ~clk;

   int total = 0;
   int passed = 0;
   int cyc = 0;

   // Stimulus controls
   bit          pending[2];
   bit          randEn = 0, spurEn = 0, alwaysReq = 0, fpPhase = 0, logOn = 0;
   bit          respOn = 1;
   logic [31:0] addrPool[5];
   int          fpGnts = 0;
   int          gLog[4];
   int          nLog = 0;

   // CLINT stub
   logic [31:0] stubMem[logic [31:0]];
   bit          prevRready = 0;
   logic [31:0] stubRaddr = 32'd0;

   // Behavioural model: one outstanding transaction with its predicted timeline
   logic [31:0] shadow[logic [31:0]];
   int          ptr = 0;
   bit          busy = 0;
   int          gCyc, aCyc, endCyc, tM;
   bit          tWe, tErr, tResp;
   logic [31:0] tAddr, tData, tRd;
   logic [3:0]  tStrb;
   logic [31:0] expRd[2];
   bit          expGnt[2], expAck[2], expErr[2];
   bit          expW, expR;

   function automatic logic [31:0] mergeStrb(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      else
         passed++;
   endtask

   task automatic failNow(input string name);
      total++;
      $display("[TB] FAIL %s cycle %0d: bounded wait expired", name, cyc);
   endtask

   task automatic issue(input int m, input bit we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
      pending[m] = 1;
      mWe[m] = we;
      mAddr[m] = a;
      mData[m] = d;
      mStrb[m] = s;
   endtask

   task automatic applyStimulus();
      bit inWait;
      for (int m = 0; m < 2; m++) begin
         if (!pending[m] && (alwaysReq || (randEn && $urandom_range(99) < 30))) begin
            pending[m] = 1;
            mWe[m]   = alwaysReq ? 1'b1 : 1'($urandom_range(1));
            mAddr[m] = alwaysReq ? addrPool[$urandom_range(4, 2)] : addrPool[$urandom_range(4)];
            mData[m] = $urandom;
            mStrb[m] = 4'($urandom_range(15));
         end else if (!pending[m]) begin
            mWe[m]   = 1'($urandom_range(1));
            mAddr[m] = $urandom;
            mData[m] = $urandom;
            mStrb[m] = 4'($urandom_range(15));
         end
         req[m] = pending[m];
      end
      if (randEn) respOn = ($urandom_range(9) != 0);
      inWait  = busy && !tWe && cyc >= gCyc + 2 && cyc < aCyc;
      s_rresp = prevRready && busy && tResp;
      s_rdata = s_rresp ? (stubMem.exists(stubRaddr) ? stubMem[stubRaddr] : 32'h0) : $urandom;
      if (spurEn && !inWait && $urandom_range(7) == 0) s_rresp = 1'b1;
   endtask

   task automatic modelCycle();
      int w;
      for (int m = 0; m < 2; m++) begin
         expGnt[m] = 0;
         expAck[m] = 0;
         expErr[m] = 0;
      end
      expW = 0;
      expR = 0;
      if (busy && cyc >= endCyc) busy = 0;
      if (!busy && (req[0] === 1'b1 || req[1] === 1'b1)) begin
         if (req[0] === 1'b1 && req[1] === 1'b1) w = ptr;
         else w = (req[1] === 1'b1) ? 1 : 0;
         expGnt[w] = 1;
         ptr   = 1 - w;
         busy  = 1;
         tM    = w;
         gCyc  = cyc;
         tWe   = mWe[w];
         tAddr = mAddr[w];
         tData = mData[w];
         tStrb = mStrb[w];
         tErr  = 0;
         tResp = respOn;
         if (tWe) begin
            aCyc = cyc + 2;
            shadow[tAddr] = mergeStrb(shadow.exists(tAddr) ? shadow[tAddr] : 32'h0, tData, tStrb);
         end else if (tResp) begin
            aCyc = cyc + 3;
            tRd  = shadow.exists(tAddr) ? shadow[tAddr] : 32'h0;
         end else begin
            aCyc = cyc + 2 + TIMEOUT;
            tRd  = 32'h0;
            tErr = 1;
         end
         endCyc = aCyc + 1;
      end
      if (busy) begin
         if (cyc == gCyc + 1) begin
            expW = tWe;
            expR = !tWe;
         end
         if (cyc == aCyc) begin
            expAck[tM] = 1;
            expErr[tM] = tErr;
            if (!tWe) expRd[tM] = tRd;
         end
      end
   endtask

   task automatic checkOutput();
      checkVal("m0_gnt", m0_gnt, expGnt[0]);
      checkVal("m1_gnt", m1_gnt, expGnt[1]);
      checkVal("s_wready", s_wready, expW);
      checkVal("s_rready", s_rready, expR);
      checkVal("m0_ack", m0_ack, expAck[0]);
      checkVal("m1_ack", m1_ack, expAck[1]);
      checkVal("m0_err", m0_err, expErr[0]);
      checkVal("m1_err", m1_err, expErr[1]);
      checkVal("m0_rdata", m0_rdata, expRd[0]);
      checkVal("m1_rdata", m1_rdata, expRd[1]);
      if (expW) begin
         checkVal("s_waddr", s_waddr, tAddr);
         checkVal("s_wdata", s_wdata, tData);
         checkVal("s_wstrb", s_wstrb, tStrb);
      end
      if (expR) checkVal("s_raddr", s_raddr, tAddr);
      checkVal("strobe_overlap", s_wready & s_rready, 0);
      if (fpPhase) begin
         checkVal("fp_m1_gnt", fp_m1_gnt, 0);
         if (fp_m0_gnt) fpGnts++;
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
      cyc++;
      applyStimulus();
      @(negedge clk);
      modelCycle();
      checkOutput();
      if (s_wready)
         stubMem[s_waddr] = mergeStrb(stubMem.exists(s_waddr) ? stubMem[s_waddr] : 32'h0,
                                      s_wdata, s_wstrb);
      prevRready = s_rready;
      stubRaddr  = s_raddr;
      for (int m = 0; m < 2; m++) if (expGnt[m]) pending[m] = 0;
      if (logOn && (m0_gnt || m1_gnt) && nLog < 4) begin
         gLog[nLog] = m1_gnt ? 1 : 0;
         nLog++;
      end
   endtask

   task automatic waitGrant(input int m, output int g);
      g = -1;
      for (int i = 0; i < 40; i++) begin
         stepCycle();
         if (expGnt[m]) begin
            g = cyc;
            break;
         end
      end
      if (g < 0) failNow("grant_wait");
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((pending[0] || pending[1] || (busy && cyc < endCyc)) && n < 200) begin
         stepCycle();
         n++;
      end
      if (n >= 200) failNow("drain_wait");
   endtask

   task automatic resetChecks(input string tag);
      checkVal({tag, "_m0_gnt"}, m0_gnt, 0);
      checkVal({tag, "_m1_gnt"}, m1_gnt, 0);
      checkVal({tag, "_m0_ack"}, m0_ack, 0);
      checkVal({tag, "_m1_ack"}, m1_ack, 0);
      checkVal({tag, "_m0_err"}, m0_err, 0);
      checkVal({tag, "_m1_err"}, m1_err, 0);
      checkVal({tag, "_m0_rdata"}, m0_rdata, 0);
      checkVal({tag, "_m1_rdata"}, m1_rdata, 0);
      checkVal({tag, "_s_wready"}, s_wready, 0);
      checkVal({tag, "_s_rready"}, s_rready, 0);
      checkVal({tag, "_s_waddr"}, s_waddr, 0);
      checkVal({tag, "_s_wdata"}, s_wdata, 0);
      checkVal({tag, "_s_wstrb"}, s_wstrb, 0);
      checkVal({tag, "_s_raddr"}, s_raddr, 0);
   endtask

   // Asserts reset mid-cycle with both requests high, checks reset values, releases it.
   task automatic pulseReset(input string tag);
      @(posedge clk);
      #1;
      cyc++;
      req[0] = 1'b1;
      req[1] = 1'b1;
      resetb = 1'b1;
      #2;
      resetChecks(tag);
      @(negedge clk);
      #1;
      req[0] = 1'b0;
      req[1] = 1'b0;
      pending[0] = 0;
      pending[1] = 0;
      resetb = 1'b0;
      busy = 0;
      ptr = 0;
      expRd[0] = 32'h0;
      expRd[1] = 32'h0;
      prevRready = 0;
      s_rresp = 1'b0;
   endtask

   initial begin
      int g;
      int expSeq[4];
      expSeq = '{0, 1, 0, 1};
      addrPool = '{MSIP_BASE, MTIMECMP_BASE, MSIP_BASE + 32'd4, MTIMECMP_BASE + 32'd4, 32'h0200_BFF8};
      for (int m = 0; m < 2; m++) begin
         req[m] = 1'b0;
         mWe[m] = 1'b0;
         mAddr[m] = 32'h0;
         mData[m] = 32'h0;
         mStrb[m] = 4'h0;
         pending[m] = 0;
         expRd[m] = 32'h0;
      end
      s_rresp = 1'b0;
      s_rdata = 32'h0;
      repeat (2) @(posedge clk);
      pulseReset("reset");

      // m0 write to MTIMECMP
      issue(0, 1'b1, MTIMECMP_BASE, 32'h0000_1234, 4'hF);
      waitGrant(0, g);
      checkVal("lit_w_gnt", m0_gnt, 1);
      stepCycle();
      checkVal("lit_w_wready", s_wready, 1);
      checkVal("lit_w_waddr", s_waddr, MTIMECMP_BASE);
      checkVal("lit_w_wdata", s_wdata, 32'h0000_1234);
      stepCycle();
      checkVal("lit_w_ack", m0_ack, 1);
      checkVal("lit_w_err", m0_err, 0);
      checkVal("lit_clint_readback", stubMem.exists(MTIMECMP_BASE) ? stubMem[MTIMECMP_BASE] : 32'hDEAD, 32'h0000_1234);

      // m1 writes then reads MSIP
      issue(1, 1'b1, MSIP_BASE, 32'h0001_0001, 4'hF);
      waitGrant(1, g);
      repeat (2) stepCycle();
      issue(1, 1'b0, MSIP_BASE, 32'h0, 4'h0);
      waitGrant(1, g);
      stepCycle();
      checkVal("lit_r_rready", s_rready, 1);
      repeat (2) stepCycle();
      checkVal("lit_r_ack", m1_ack, 1);
      checkVal("lit_r_rdata", m1_rdata, 32'h0001_0001);
      checkVal("lit_r_err", m1_err, 0);

      // Both masters request every cycle
      alwaysReq = 1;
      fpPhase = 1;
      logOn = 1;
      repeat (24) stepCycle();
      alwaysReq = 0;
      fpPhase = 0;
      logOn = 0;
      checkVal("rr_grant_count", nLog, 4);
      for (int i = 0; i < 4; i++) checkVal("rr_grant_order", gLog[i], expSeq[i]);
      checkVal("fp_m0_grants", fpGnts, 8);
      drain();

      // Read timeout, then a normal read
      respOn = 0;
      issue(0, 1'b0, MSIP_BASE + 32'd4, 32'h0, 4'h0);
      waitGrant(0, g);
      repeat (9) stepCycle();
      checkVal("lit_to_noack_early", m0_ack, 0);
      stepCycle();
      checkVal("lit_to_ack", m0_ack, 1);
      checkVal("lit_to_err", m0_err, 1);
      checkVal("lit_to_rdata", m0_rdata, 32'h0);
      respOn = 1;
      issue(0, 1'b0, MTIMECMP_BASE, 32'h0, 4'h0);
      waitGrant(0, g);
      repeat (3) stepCycle();
      checkVal("lit_after_to_ack", m0_ack, 1);
      checkVal("lit_after_to_err", m0_err, 0);
      checkVal("lit_after_to_rdata", m0_rdata, 32'h0000_1234);

      // Reset during WAIT, then a fresh m1 read
      respOn = 0;
      issue(1, 1'b0, MSIP_BASE, 32'h0, 4'h0);
      waitGrant(1, g);
      repeat (2) stepCycle();
      pulseReset("midrst");
      respOn = 1;
      issue(1, 1'b0, MSIP_BASE, 32'h0, 4'h0);
      waitGrant(1, g);
      repeat (3) stepCycle();
      checkVal("lit_postrst_ack", m1_ack, 1);
      checkVal("lit_postrst_rdata", m1_rdata, 32'h0001_0001);

      // m1 request arrives while an m0 write is in ISSUE
      issue(0, 1'b1, MSIP_BASE + 32'd4, 32'hCAFE_0001, 4'hF);
      waitGrant(0, g);
      issue(1, 1'b0, MSIP_BASE, 32'h0, 4'h0);
      repeat (2) stepCycle();
      checkVal("lit_wait_nognt", m1_gnt, 0);
      stepCycle();
      checkVal("lit_late_gnt", m1_gnt, 1);
      drain();

      // Randomized traffic with spurious responses and occasional timeouts
      randEn = 1;
      spurEn = 1;
      repeat (1500) stepCycle();
      randEn = 0;
      spurEn = 0;
      respOn = 1;
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
